// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler: RV32I opcodes, execution-unit codes,
// FSM states, the queue entry layout and the opcode classifier.
package issue_scheduler_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_LSU = 2'd1,
    UNIT_BR  = 2'd2,
    UNIT_ILL = 2'd3
  } unit_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BRWAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic unit_t classify(input logic [6:0] opcode);
    unit_t unit;
    unit = UNIT_ILL;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_FENCE: unit = UNIT_ALU;
      OPC_LOAD, OPC_STORE:                               unit = UNIT_LSU;
      OPC_JAL, OPC_JALR, OPC_BRANCH:                     unit = UNIT_BR;
      default:                                           unit = UNIT_ILL;
    endcase
    return unit;
  endfunction

endpackage

// File: rtl/issue_queue.sv
// Circular FIFO holding fetched {instr, pc} entries; clear empties it in one cycle.
// A push is refused whenever the queue is full, even if a pop happens in the same cycle.
module issue_queue
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[head];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clock) begin
    if (do_push && !reset && !clear) mem[tail] <= push_data;
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler: queues fetched instructions, classifies the head,
// and issues it when the ROB and its unit have room; stalls behind control transfers.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        rob_free,
  input  logic        rs_alu_free,
  input  logic        rs_lsu_free,
  input  logic        rs_br_free,
  input  logic        branch_resolved,
  input  logic        flush,
  output logic        issue_valid,
  output logic [31:0] issue_instr,
  output logic [31:0] issue_pc,
  output logic [1:0]  issue_unit,
  output logic        br_pending
);

  state_t               state;
  state_t               state_next;
  entry_t               head_entry;
  logic [ENTRY_W-1:0]   head_bits;
  logic [PTR_W:0]       count;
  logic                 q_full;
  logic                 q_empty;
  logic                 push;
  unit_t                head_unit;
  logic                 unit_free;
  logic                 go;

  // A push in a flush cycle is dropped along with everything already buffered.
  assign push        = fetch_valid && fetch_ready && !flush;
  assign fetch_ready = !q_full;
  assign head_entry  = head_bits;
  assign br_pending  = (state == ST_BRWAIT);

  issue_queue #(
    .DEPTH (QUEUE_DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .pop       (go),
    .push_data ({fetch_instr, fetch_pc}),
    .head_data (head_bits),
    .count     (count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Illegal opcodes need only a ROB slot; the ROB reports the exception later.
  always_comb begin
    head_unit = classify(head_entry.instr[6:0]);
    unit_free = 1'b1;
    case (head_unit)
      UNIT_ALU: unit_free = rs_alu_free;
      UNIT_LSU: unit_free = rs_lsu_free;
      UNIT_BR:  unit_free = rs_br_free;
      default:  unit_free = 1'b1;
    endcase
    go = (state == ST_RUN) && !q_empty && rob_free && unit_free && !flush;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN:    if (go && head_unit == UNIT_BR) state_next = ST_BRWAIT;
        ST_BRWAIT: if (branch_resolved)            state_next = ST_RUN;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Issue fields keep their last values while issue_valid is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_instr <= '0;
      issue_pc    <= '0;
      issue_unit  <= '0;
    end else begin
      issue_valid <= go;
      if (go) begin
        issue_instr <= head_entry.instr;
        issue_pc    <= head_entry.pc;
        issue_unit  <= head_unit;
      end
    end
  end

endmodule
